// File: rtl/regbank_if.sv
// Decode <-> register bank interface: operand reads, issue tracking,
// WB write port and the resulting stall/error indications.
// Optional feature macro (used by regbank_scoreboard): REGBANK_STALL_COUNT_EN.

`ifndef REG_ADDR
`define REG_ADDR 5
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

interface regbank_if;
  logic [`REG_ADDR-1:0] rd_addr1;
  logic [`REG_ADDR-1:0] rd_addr2;
  logic                 rd_use1;
  logic                 rd_use2;
  logic [`REG_SIZE-1:0] rd_data1;
  logic [`REG_SIZE-1:0] rd_data2;
  logic                 issue_valid;
  logic                 issue_regwrite;
  logic [`REG_ADDR-1:0] issue_dest;
  logic                 wb_we;
  logic [`REG_ADDR-1:0] wb_addr;
  logic [`REG_SIZE-1:0] wb_data;
  logic                 stall;
  logic                 err_underflow;

  // Decode/WB side: drives addresses, issue and write-back.
  modport master (
    output rd_addr1, rd_addr2, rd_use1, rd_use2,
    output issue_valid, issue_regwrite, issue_dest,
    output wb_we, wb_addr, wb_data,
    input  rd_data1, rd_data2, stall, err_underflow
  );

  // Register bank side.
  modport slave (
    input  rd_addr1, rd_addr2, rd_use1, rd_use2,
    input  issue_valid, issue_regwrite, issue_dest,
    input  wb_we, wb_addr, wb_data,
    output rd_data1, rd_data2, stall, err_underflow
  );
endinterface

// File: rtl/regbank_scoreboard.sv
// Register file with write-through bypass plus a per-register pending-write
// scoreboard that raises stall on RAW hazards or a saturated counter.
// Optional feature macro: REGBANK_STALL_COUNT_EN adds a saturating
// stall_cycles output counting stalled cycles.

`ifndef REG_ADDR
`define REG_ADDR 5
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module regbank_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  regbank_if.slave    bus
`ifdef REGBANK_STALL_COUNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [`REG_SIZE-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]     cnt_q  [NREGS];
  logic [CNT_W-1:0]     cnt_d  [NREGS];
  logic                 err_q, err_d;

  logic             retire, issue_req, issue_fire;
  logic             haz1, haz2, full;
  logic [NREGS-1:0] inc_vec, dec_vec;

  // Operand reads: r0 is zero, then WB bypass, then the stored value.
  always_comb begin
    if (bus.rd_addr1 == '0)                          bus.rd_data1 = '0;
    else if (bus.wb_we && bus.wb_addr == bus.rd_addr1) bus.rd_data1 = bus.wb_data;
    else                                             bus.rd_data1 = regs_q[bus.rd_addr1];
    if (bus.rd_addr2 == '0)                          bus.rd_data2 = '0;
    else if (bus.wb_we && bus.wb_addr == bus.rd_addr2) bus.rd_data2 = bus.wb_data;
    else                                             bus.rd_data2 = regs_q[bus.rd_addr2];
  end

  // Hazard detection; a last pending write retiring this cycle is covered by the bypass.
  always_comb begin
    retire    = bus.wb_we && (bus.wb_addr != '0);
    issue_req = bus.issue_valid && bus.issue_regwrite && (bus.issue_dest != '0);
    haz1 = bus.rd_use1 && (bus.rd_addr1 != '0) && (cnt_q[bus.rd_addr1] != CNT_ZERO) &&
           !((cnt_q[bus.rd_addr1] == CNT_ONE) && retire && (bus.wb_addr == bus.rd_addr1));
    haz2 = bus.rd_use2 && (bus.rd_addr2 != '0) && (cnt_q[bus.rd_addr2] != CNT_ZERO) &&
           !((cnt_q[bus.rd_addr2] == CNT_ONE) && retire && (bus.wb_addr == bus.rd_addr2));
    full       = issue_req && (cnt_q[bus.issue_dest] == CNT_MAX);
    bus.stall  = haz1 || haz2 || full;
    issue_fire = issue_req && !bus.stall;
    bus.err_underflow = err_q;
  end

  // Scoreboard next state: simultaneous inc/dec on one register cancel out.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    err_d   = err_q;
    inc_vec = issue_fire ? (NREGS'(1) << bus.issue_dest) : '0;
    dec_vec = retire     ? (NREGS'(1) << bus.wb_addr)    : '0;
    for (int r = 1; r < NREGS; r++) begin
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == CNT_ZERO) err_d    = 1'b1;
        else                      cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  // State registers: register file, counters and sticky error.
  // NOTE: the register file is reset on purpose -- all registers must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (retire) regs_q[bus.wb_addr] <= bus.wb_data;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

`ifdef REGBANK_STALL_COUNT_EN
  logic [31:0] stall_cycles_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset)                             stall_cycles_q <= '0;
    else if (bus.stall && !(&stall_cycles_q)) stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
